// File: rtl/drv_bin2bcd_w.sv
// Sequential binary-to-BCD converter (double dabble, one iteration per clock)
// with overflow saturation and per-digit leading-zero flags for a segment driver.
module drv_bin2bcd_w #(
  parameter int p_width     = 4,
  parameter int p_bin_width = 14
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [p_bin_width-1:0] i_bin,
  output logic [3:0]             o_value [p_width-1:0],
  output logic [p_width-1:0]     o_blank,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_ovf
);

  localparam int CNT_W = $clog2(p_bin_width + 1);
  localparam int SW    = 4 * p_width;

  function automatic logic [63:0] max_val();
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < p_width; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] LIM = max_val();

  // One double-dabble step: +3 on nibbles >= 5, then shift in the next binary bit.
  function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s, input logic b);
    logic [SW-1:0] adj;
    for (int i = 0; i < p_width; i++)
      adj[4*i +: 4] = (s[4*i +: 4] >= 4'd5) ? s[4*i +: 4] + 4'd3 : s[4*i +: 4];
    return (adj << 1) | SW'(b);
  endfunction

  function automatic logic [SW-1:0] sat_bcd(input logic [SW-1:0] s, input logic ovf);
    logic [SW-1:0] r;
    for (int i = 0; i < p_width; i++) r[4*i +: 4] = ovf ? 4'd9 : s[4*i +: 4];
    return r;
  endfunction

  function automatic logic [p_width-1:0] blank_of(input logic [SW-1:0] s);
    logic [p_width-1:0] b;
    logic               allz;
    b    = '0;
    allz = 1'b1;
    for (int i = p_width - 1; i > 0; i--) begin
      allz = allz & (s[4*i +: 4] == 4'd0);
      b[i] = allz;
    end
    return b;
  endfunction

  typedef enum logic {IDLE, CONV} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt;
  logic [SW-1:0]          scratch, scratch_next, result;
  logic [p_bin_width-1:0] shreg;
  logic                   ovf_next;
  logic                   accept, last;

  assign accept       = (state == IDLE) && i_start;
  assign last         = (state == CONV) && (cnt == CNT_W'(p_bin_width - 1));
  assign scratch_next = dabble_step(scratch, shreg[p_bin_width-1]);
  assign result       = sat_bcd(scratch_next, ovf_next);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;

  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    case (state)
      IDLE: if (i_start) state_next = CONV;
      CONV: begin
        o_busy = 1'b1;
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt      <= '0;
      scratch  <= '0;
      shreg    <= '0;
      ovf_next <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      scratch  <= '0;
      shreg    <= i_bin;
      ovf_next <= 64'(i_bin) > LIM;
    end else if (state == CONV) begin
      cnt      <= cnt + CNT_W'(1);
      scratch  <= scratch_next;
      shreg    <= shreg << 1;
    end

  // Result registers only move on the completing edge and hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < p_width; i++) o_value[i] <= 4'd0;
      o_blank <= ~p_width'(1);
      o_done  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_done <= last;
      if (last) begin
        for (int i = 0; i < p_width; i++) o_value[i] <= result[4*i +: 4];
        o_blank <= ovf_next ? '0 : blank_of(scratch_next);
        o_ovf   <= ovf_next;
      end
    end

endmodule

// File: tb/tb_drv_bin2bcd_w.sv
// Directed bench for drv_bin2bcd_w: latency, digits, blanking, overflow,
// start-while-busy, back-to-back starts and asynchronous reset mid-conversion.
module tb_drv_bin2bcd_w;
  localparam int W  = 4;
  localparam int BW = 14;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [BW-1:0] bin   = '0;
  logic [3:0]    value [W-1:0];
  logic [W-1:0]  blank;
  logic          busy, done, ovf;

  int checks = 0;
  int errors = 0;

  drv_bin2bcd_w #(.p_width(W), .p_bin_width(BW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_bin   (bin),
    .o_value (value),
    .o_blank (blank),
    .o_busy  (busy),
    .o_done  (done),
    .o_ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {value[3], value[2], value[1], value[0]};
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] ref_blank(input int v);
    logic [3:0] b;
    b = 4'b0000;
    if (v > 9999) return b;
    if (v < 1000) b[3] = 1'b1;
    if (v < 100)  b[2] = 1'b1;
    if (v < 10)   b[1] = 1'b1;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges counted from the accepting edge until o_done; busy must hold meanwhile.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    do begin
      tick();
      n++;
      if (!done) check("busy_during", busy, 1'b1);
    end while (!done && n < 30);
  endtask

  task automatic check_result(input string tag, input int v);
    check({tag, "_val"},   digits(), ref_bcd(v));
    check({tag, "_blank"}, blank,    ref_blank(v));
    check({tag, "_ovf"},   ovf,      (v > 9999));
    check({tag, "_busy"},  busy,     1'b0);
  endtask

  task automatic convert(input int v, input string tag);
    int n;
    start = 1'b1;
    bin   = BW'(v);
    tick();
    start = 1'b0;
    bin   = BW'($urandom);
    check({tag, "_busy_start"}, busy, 1'b1);
    wait_done(0, n);
    check({tag, "_lat"}, n, 14);
    check_result(tag, v);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n;
    int dcount;
    int vec[$] = '{1234, 0, 7, 40, 9999, 12000, 5, 1, 10, 100, 999, 1000, 10000, 16383};

    #2 rst_n = 1'b0;
    #1;
    check("rst_val",   digits(), 16'h0000);
    check("rst_blank", blank,    4'b1110);
    check("rst_busy",  busy,     1'b0);
    check("rst_done",  done,     1'b0);
    check("rst_ovf",   ovf,      1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    foreach (vec[i]) convert(vec[i], $sformatf("v%0d", vec[i]));

    // Results hold while idle with a changing i_bin.
    repeat (5) begin
      bin = BW'($urandom);
      tick();
    end
    check("hold_val",  digits(), ref_bcd(16383));
    check("hold_ovf",  ovf,      1'b1);
    check("hold_done", done,     1'b0);

    // Start while busy is ignored; start in the done cycle is accepted.
    start = 1'b1;
    bin   = BW'(1234);
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    bin   = BW'(42);
    tick();
    start = 1'b0;
    wait_done(5, n);
    check("ign_lat", n, 14);
    check_result("ign", 1234);
    start = 1'b1;
    bin   = BW'(42);
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    wait_done(0, n);
    check("b2b_lat", n, 14);
    check_result("b2b", 42);
    dcount = 0;
    repeat (20) begin
      tick();
      if (done) dcount++;
    end
    check("no_extra_done", dcount, 0);

    // Asynchronous reset mid-conversion, with o_ovf previously set.
    convert(12000, "pre_rst");
    start = 1'b1;
    bin   = BW'(1234);
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_val",   digits(), 16'h0000);
    check("arst_blank", blank,    4'b1110);
    check("arst_busy",  busy,     1'b0);
    check("arst_done",  done,     1'b0);
    check("arst_ovf",   ovf,      1'b0);
    dcount = 0;
    repeat (16) begin
      tick();
      if (done || busy) dcount++;
    end
    check("arst_quiet", dcount, 0);
    #3 rst_n = 1'b1;
    convert(1234, "post_rst");

    // Random sweep against the reference model.
    repeat (20) begin
      int v;
      v = int'($urandom_range(0, 16383));
      convert(v, $sformatf("r%0d", v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1);
  end
endmodule
